// File: rtl/on_run_logger_if.sv
// Run-length output stream: valid/ready handshake carrying one completed ON-run length per beat.
interface on_run_logger_if #(
    parameter int CNT_W = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/on_run_logger.sv
// Measures the length of every ON run of 'in' and queues completed lengths in a small FIFO.
// Runs that find the FIFO full (with no simultaneous pop) are dropped and flagged in 'overflow'.
module on_run_logger #(
    parameter int CNT_W = 16,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                in,
    input  logic                clr_ovf,
    on_run_logger_if.master     out_if,
    output logic                busy,
    output logic                overflow,
    output logic [CNT_W-1:0]    run_total
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             prev_in;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      occ;
    logic             done, full, pop, push_ok, drop;

    assign done    = prev_in & ~in;
    assign full    = (occ == (AW+1)'(DEPTH));
    assign pop     = out_if.out_valid & out_if.out_ready;
    // A pop at the same edge frees the slot the push needs.
    assign push_ok = done & (~full | pop);
    assign drop    = done & full & ~pop;

    assign out_if.out_valid = (occ != '0);
    assign out_if.out_data  = mem[rptr];
    assign busy             = prev_in;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            prev_in   <= 1'b0;
            run_cnt   <= '0;
            run_total <= '0;
            wptr      <= '0;
            rptr      <= '0;
            occ       <= '0;
            overflow  <= 1'b0;
        end else begin
            prev_in <= in;
            if (in) begin
                if (!prev_in)
                    run_cnt <= CNT_W'(1);
                else if (run_cnt != {CNT_W{1'b1}})
                    run_cnt <= run_cnt + CNT_W'(1);
            end
            if (done)
                run_total <= run_total + CNT_W'(1);
            if (push_ok)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
            // A drop at the same edge as a clear request keeps the flag set.
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    // Storage carries no reset; out_data is only meaningful while out_valid is high.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= run_cnt;
    end
endmodule

// File: tb/tb_on_run_logger.sv
// Randomized and directed checks of on_run_logger against a queue-based run-length model.
// Two instances (CNT_W=16 and CNT_W=4) share stimulus so saturation and wrap are checked too.
module tb_on_run_logger;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic areset = 1'b1;
    logic in_ = 1'b0;
    logic clr = 1'b0;
    logic rdy = 1'b0;

    logic        busy16, ovf16, busy4, ovf4;
    logic [15:0] total16;
    logic [3:0]  total4;

    on_run_logger_if #(.CNT_W(16)) if16 ();
    on_run_logger_if #(.CNT_W(4))  if4 ();

    on_run_logger #(.CNT_W(16), .DEPTH(DEPTH)) dut16 (
        .clk(clk), .areset(areset), .in(in_), .clr_ovf(clr), .out_if(if16.master),
        .busy(busy16), .overflow(ovf16), .run_total(total16));
    on_run_logger #(.CNT_W(4), .DEPTH(DEPTH)) dut4 (
        .clk(clk), .areset(areset), .in(in_), .clr_ovf(clr), .out_if(if4.master),
        .busy(busy4), .overflow(ovf4), .run_total(total4));

    assign if16.out_ready = rdy;
    assign if4.out_ready  = rdy;

    always #5 clk = ~clk;

    // Reference model: true (unsaturated) run lengths in a queue
    int  q[$];
    int  cur, total;
    bit  prev, ovf, m_full, m_pop, m_drop;
    int  n_chk, n_fail;

    function automatic int sat(input int len, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (len > mx) ? mx : len;
    endfunction

    task automatic model_clear();
        q.delete();
        cur = 0; total = 0; prev = 0; ovf = 0;
    endtask

    always @(posedge clk) begin
        if (areset) begin
            model_clear();
        end else begin
            m_full = (q.size() == DEPTH);
            m_pop  = (q.size() > 0) && rdy;
            m_drop = 0;
            if (m_pop) void'(q.pop_front());
            if (prev && !in_) begin
                total++;
                if (!m_full || m_pop) q.push_back(cur);
                else m_drop = 1;
            end
            if (m_drop) ovf = 1;
            else if (clr) ovf = 0;
            if (in_) cur = prev ? cur + 1 : 1;
            prev = in_;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("busy16", 32'(busy16), 32'(prev));
        chk("busy4", 32'(busy4), 32'(prev));
        chk("valid16", 32'(if16.out_valid), 32'(q.size() > 0));
        chk("valid4", 32'(if4.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("data16", 32'(if16.out_data), 32'(sat(q[0], 16)));
            chk("data4", 32'(if4.out_data), 32'(sat(q[0], 4)));
        end
        chk("ovf16", 32'(ovf16), 32'(ovf));
        chk("ovf4", 32'(ovf4), 32'(ovf));
        chk("total16", 32'(total16), total & 32'hffff);
        chk("total4", 32'(total4), total & 32'hf);
    endtask

    // Called at a negedge; applies inputs for the next posedge and checks after it.
    task automatic step(input logic i, input logic r, input logic c);
        in_ = i; rdy = r; clr = c;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // Asserts reset between edges and checks that outputs clear without a clock.
    task automatic do_reset();
        #2 areset = 1'b1;
        #1;
        chk("rst_valid", 32'(if16.out_valid), 0);
        chk("rst_busy", 32'(busy16), 0);
        chk("rst_ovf", 32'(ovf16), 0);
        chk("rst_total", 32'(total16), 0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
        check_all();
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        model_clear();
        repeat (2) @(negedge clk);
        areset = 1'b0;
        check_all();

        // 3-cycle run
        repeat (3) step(1, 0, 0);
        step(0, 0, 0);
        chk("r31_data", 32'(if16.out_data), 3);
        chk("r31_valid", 32'(if16.out_valid), 1);
        chk("r31_total", 32'(total16), 1);
        step(0, 1, 0);

        // Five 1-cycle pulses into a 4-deep FIFO with no consumer
        do_reset();
        repeat (5) begin step(1, 0, 0); step(0, 0, 0); end
        chk("r32_ovf", 32'(ovf16), 1);
        chk("r32_total", 32'(total16), 5);
        chk("r32_head", 32'(if16.out_data), 1);

        // Clear request loses to a simultaneous drop, then clears alone
        step(1, 0, 0);
        step(0, 0, 1);
        chk("r36_keep", 32'(ovf16), 1);
        step(0, 0, 1);
        chk("r36_clear", 32'(ovf16), 0);

        // Full FIFO, pop coincides with completion of a length-2 run
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        chk("r33_ovf", 32'(ovf16), 0);
        repeat (3) step(0, 1, 0);
        chk("r33_tail", 32'(if16.out_data), 2);
        chk("r33_valid", 32'(if16.out_valid), 1);
        step(0, 1, 0);
        chk("r33_empty", 32'(if16.out_valid), 0);

        // 20-cycle run saturates the narrow instance
        repeat (20) step(1, 0, 0);
        step(0, 0, 0);
        chk("r34_data4", 32'(if4.out_data), 15);
        chk("r34_data16", 32'(if16.out_data), 20);

        // Reset mid-run with two entries queued, then a run starting on the first edge
        step(1, 0, 0);
        step(0, 0, 0);
        repeat (2) step(1, 0, 0);
        do_reset();
        chk("r35_total", 32'(total16), 0);
        step(1, 0, 0);
        step(0, 0, 0);
        chk("r30_data", 32'(if16.out_data), 1);
        chk("r30_total", 32'(total16), 1);

        // Randomized traffic with alternating consumer pressure
        for (int n = 0; n < 3000; n++) begin
            logic ni, nr, nc;
            ni = ($urandom_range(0, 9) < 2) ? ~in_ : in_;
            if ((n / 128) % 2 == 0) nr = ($urandom_range(0, 3) != 0);
            else                    nr = ($urandom_range(0, 7) == 0);
            nc = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 799) == 0) do_reset();
            else step(ni, nr, nc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
